// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: op codes, error codes and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_MOD    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_NAND   = 4'd7;
    localparam logic [3:0] OP_NOR    = 4'd8;
    localparam logic [3:0] OP_XOR    = 4'd9;
    localparam logic [3:0] OP_XNOR   = 4'd10;
    localparam logic [3:0] OP_NOT    = 4'd11;
    localparam logic [3:0] OP_PRESET = 4'd12;
    localparam logic [3:0] OP_CLEAR  = 4'd13;
    localparam logic [3:0] OP_NOP    = 4'd14;
    localparam logic [3:0] OP_RSVD   = 4'd15;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_DIV0  = 2'b10;
    localparam logic [1:0] ERR_FAULT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Ops 12..15 are resolved locally and never reach the ALU.
    function automatic logic is_bypass(input logic [3:0] op);
        return op >= OP_PRESET;
    endfunction

    // Overflow only has meaning for add/sub; other ops drop that bit.
    function automatic logic [1:0] mask_err(input logic [3:0] op, input logic [1:0] err);
        return {err[1], err[0] & ((op == OP_ADD) || (op == OP_SUB))};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two depth, count-based full/empty, head visible combinationally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, issues them one at a time to a shared ALU and folds results
// into an accumulator with sticky error tracking and a per-command response pulse.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        alu_start,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_err,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_err,
    output logic [31:0] acc,
    output logic [1:0]  err_sticky,
    output logic        busy,
    output state_t      fsm_state
);
    localparam int             TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both
    // high; cmd_ready depends only on FIFO fullness, never on cmd_valid. rsp_valid is a
    // one-cycle pulse with no back-pressure.
    state_t        state;
    state_t        state_nxt;
    logic          ready_en;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [19:0]   head;
    logic [3:0]    head_op;
    logic [15:0]   head_data;
    logic [3:0]    cur_op;
    logic [15:0]   cur_data;
    logic [31:0]   res_q;
    logic [1:0]    err_q;
    logic [TW-1:0] tmo_cnt;

    assign head_op   = head[19:16];
    assign head_data = head[15:0];
    assign cmd_ready = ready_en & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == S_ISSUE);

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(20)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cmd_op, cmd_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // WB chains straight into ISSUE when work is queued, giving a 3-cycle command loop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = is_bypass(head_op) ? S_WB : S_WAIT;
            S_WAIT:  if (alu_done || (tmo_cnt == TO_LAST)) state_nxt = S_WB;
            S_WB:    state_nxt = empty ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            cur_op     <= '0;
            cur_data   <= '0;
            res_q      <= '0;
            err_q      <= ERR_NONE;
            tmo_cnt    <= '0;
            acc        <= '0;
            err_sticky <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_ISSUE: begin
                    cur_op   <= head_op;
                    cur_data <= head_data;
                    tmo_cnt  <= '0;
                    case (head_op)
                        OP_PRESET: begin res_q <= '1;  err_q <= ERR_NONE;  end
                        OP_CLEAR:  begin res_q <= '0;  err_q <= ERR_NONE;  end
                        OP_NOP:    begin res_q <= acc; err_q <= ERR_NONE;  end
                        OP_RSVD:   begin res_q <= acc; err_q <= ERR_FAULT; end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (alu_done) begin
                        res_q <= alu_result;
                        err_q <= mask_err(cur_op, alu_err);
                    end else if (tmo_cnt == TO_LAST) begin
                        res_q <= acc;
                        err_q <= ERR_FAULT;
                    end
                end
                S_WB: begin
                    if (err_q == ERR_NONE) acc <= res_q;
                    err_sticky <= err_sticky | err_q;
                end
                default: ;
            endcase
        end
    end

    // During ISSUE the request comes straight from the FIFO head; afterwards the latched
    // copy keeps it stable for the whole WAIT. acc cannot change before WB.
    assign alu_start  = (state == S_ISSUE) && !is_bypass(head_op);
    assign alu_op     = (state == S_ISSUE) ? head_op   : cur_op;
    assign alu_a      = (state == S_ISSUE) ? head_data : cur_data;
    assign alu_b      = acc[15:0];
    assign rsp_valid  = (state == S_WB);
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
    assign busy       = (state != S_IDLE) | ~empty;
    assign fsm_state  = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus hand-written timeout, reset and FIFO-full sequences.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [1:0]  alu_err;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_err;
    logic [31:0] acc;
    logic [1:0]  err_sticky;
    logic        busy;
    state_t      fsm_state;

    alu_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .acc        (acc),
        .err_sticky (err_sticky),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- ALU responder ----------------
    logic [33:0] alu_rsp_q[$];
    logic [33:0] pend_val;
    logic [33:0] stray_val;
    bit          pending;
    bit          stall;
    bit          stray;
    int          start_cnt;
    int          cyc;
    int          start_cyc[$];
    logic [15:0] last_a;
    logic [15:0] last_b;
    logic [3:0]  last_op;

    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        alu_err    = '0;
        pending    = 0;
        start_cnt  = 0;
        cyc        = 0;
        forever begin
            @(negedge clk);
            cyc++;
            alu_done = 1'b0;
            if (pending) begin
                alu_done               = 1'b1;
                {alu_err, alu_result}  = pend_val;
                pending                = 0;
            end else if (stray) begin
                alu_done               = 1'b1;
                {alu_err, alu_result}  = stray_val;
                stray                  = 0;
            end
            if (rst_n && alu_start) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                last_a  = alu_a;
                last_b  = alu_b;
                last_op = alu_op;
                if (!stall && alu_rsp_q.size() > 0) begin
                    pend_val = alu_rsp_q.pop_front();
                    pending  = 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int          rsp_cnt = 0;

    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {rsp_err, rsp_result}, 34'h0);
                    check("rsp_unexpected_valid", 34'(rsp_valid), 34'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rsp%0d", rsp_cnt), {rsp_err, rsp_result}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [3:0] op, input logic [15:0] d);
        int n;
        n         = 0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 34'(cmd_ready), 34'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrived", 34'(rsp_cnt >= target), 34'd1);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 34'(alu_start), 34'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic [31:0] alu_res;
        logic [1:0]  alu_e;
        bit          starts;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [31:0] exp_res;
        logic [1:0]  exp_err;
        logic [31:0] exp_acc;
        logic [1:0]  exp_sticky;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s0;
        int r0;
        int n;
        logic [31:0] fifo_res[6];

        vecs[0] = '{OP_ADD,    16'd11,   32'd11,         2'b00, 1'b1, 16'd11,   16'd0,  32'd11,         2'b00, 32'd11,         2'b00};
        vecs[1] = '{OP_SUB,    16'd15,   32'd4,          2'b00, 1'b1, 16'd15,   16'd11, 32'd4,          2'b00, 32'd4,          2'b00};
        vecs[2] = '{OP_DIV,    16'd8,    32'd0,          2'b10, 1'b1, 16'd8,    16'd4,  32'd0,          2'b10, 32'd4,          2'b10};
        vecs[3] = '{OP_MUL,    16'd3,    32'd12,         2'b01, 1'b1, 16'd3,    16'd4,  32'd12,         2'b00, 32'd12,         2'b10};
        vecs[4] = '{OP_ADD,    16'hFFFF, 32'h0001_000B,  2'b01, 1'b1, 16'hFFFF, 16'd12, 32'h0001_000B,  2'b01, 32'd12,         2'b11};
        vecs[5] = '{OP_XOR,    16'd5,    32'd9,          2'b00, 1'b1, 16'd5,    16'd12, 32'd9,          2'b00, 32'd9,          2'b11};
        vecs[6] = '{OP_PRESET, 16'h1234, 32'd0,          2'b00, 1'b0, 16'd0,    16'd0,  32'hFFFF_FFFF,  2'b00, 32'hFFFF_FFFF,  2'b11};
        vecs[7] = '{OP_NOP,    16'd0,    32'd0,          2'b00, 1'b0, 16'd0,    16'd0,  32'hFFFF_FFFF,  2'b00, 32'hFFFF_FFFF,  2'b11};
        vecs[8] = '{OP_CLEAR,  16'd0,    32'd0,          2'b00, 1'b0, 16'd0,    16'd0,  32'd0,          2'b00, 32'd0,          2'b11};
        vecs[9] = '{OP_RSVD,   16'd7,    32'd0,          2'b00, 1'b0, 16'd0,    16'd0,  32'd0,          2'b11, 32'd0,          2'b11};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        stall     = 0;
        stray     = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_acc",       acc,                  34'd0);
        check("rst_sticky",    34'(err_sticky),      34'd0);
        check("rst_ready",     34'(cmd_ready),       34'd0);
        check("rst_busy",      34'(busy),            34'd0);
        check("rst_rsp_valid", 34'(rsp_valid),       34'd0);
        check("rst_start",     34'(alu_start),       34'd0);
        check("rst_state",     34'(fsm_state),       34'(S_IDLE));
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 34'(cmd_ready), 34'd0);
        @(negedge clk);
        check("ready_after_edge", 34'(cmd_ready), 34'd1);

        // table-driven single commands
        for (int i = 0; i < 10; i++) begin
            s0 = start_cnt;
            r0 = rsp_cnt;
            if (vecs[i].starts) alu_rsp_q.push_back({vecs[i].alu_e, vecs[i].alu_res});
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_res});
            push_cmd(vecs[i].op, vecs[i].data);
            wait_rsp(r0 + 1);
            @(negedge clk);
            check($sformatf("v%0d_starts", i), 34'(start_cnt - s0), 34'(vecs[i].starts));
            if (vecs[i].starts) begin
                check($sformatf("v%0d_alu_a", i),  34'(last_a),  34'(vecs[i].exp_a));
                check($sformatf("v%0d_alu_b", i),  34'(last_b),  34'(vecs[i].exp_b));
                check($sformatf("v%0d_alu_op", i), 34'(last_op), 34'(vecs[i].op));
            end
            check($sformatf("v%0d_acc", i),    34'(acc),        34'(vecs[i].exp_acc));
            check($sformatf("v%0d_sticky", i), 34'(err_sticky), 34'(vecs[i].exp_sticky));
        end

        // timeout: load acc with 7, then a mul whose ALU never answers
        r0 = rsp_cnt;
        alu_rsp_q.push_back({2'b00, 32'd7});
        exp_q.push_back({2'b00, 32'd7});
        push_cmd(OP_ADD, 16'd7);
        wait_rsp(r0 + 1);
        @(negedge clk);
        check("to_pre_acc", 34'(acc), 34'd7);
        stall = 1;
        exp_q.push_back({2'b11, 32'd7});
        push_cmd(OP_MUL, 16'd2);
        wait_start();
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 34'(n), 34'd65);
        @(negedge clk);
        check("to_acc",    34'(acc),        34'd7);
        check("to_sticky", 34'(err_sticky), 34'd3);

        // reset while waiting on the ALU, with a second command queued
        push_cmd(OP_ADD, 16'd3);
        wait_start();
        repeat (5) @(negedge clk);
        push_cmd(OP_NOP, 16'd0);
        check("mid_busy", 34'(busy), 34'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc",    34'(acc),        34'd0);
        check("mid_rst_sticky", 34'(err_sticky), 34'd0);
        check("mid_rst_ready",  34'(cmd_ready),  34'd0);
        check("mid_rst_busy",   34'(busy),       34'd0);
        check("mid_rst_rsp",    34'(rsp_valid),  34'd0);
        check("mid_rst_start",  34'(alu_start),  34'd0);
        check("mid_rst_alu_a",  34'(alu_a),      34'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        r0        = rsp_cnt;
        stray_val = {2'b00, 32'h0000_BEEF};
        stray     = 1;
        repeat (6) @(negedge clk);
        check("stray_no_rsp", 34'(rsp_cnt - r0), 34'd0);
        check("stray_acc",    34'(acc),          34'd0);
        check("stray_busy",   34'(busy),         34'd0);
        check("stray_state",  34'(fsm_state),    34'(S_IDLE));

        // FIFO full: first command stalls to timeout, four fill the FIFO, the fifth waits for a pop
        fifo_res[1] = 32'd2;
        fifo_res[2] = 32'd5;
        fifo_res[3] = 32'd9;
        fifo_res[4] = 32'd14;
        fifo_res[5] = 32'd20;
        stall = 1;
        r0    = rsp_cnt;
        s0    = start_cyc.size();
        exp_q.push_back({2'b11, 32'd0});
        push_cmd(OP_ADD, 16'd1);
        wait_start();
        @(negedge clk);
        stall = 0;
        for (int i = 1; i <= 4; i++) begin
            alu_rsp_q.push_back({2'b00, fifo_res[i]});
            exp_q.push_back({2'b00, fifo_res[i]});
            push_cmd(OP_ADD, 16'(i + 1));
        end
        check("full_ready_low", 34'(cmd_ready), 34'd0);
        check("full_busy",      34'(busy),      34'd1);
        alu_rsp_q.push_back({2'b00, fifo_res[5]});
        exp_q.push_back({2'b00, fifo_res[5]});
        push_cmd(OP_ADD, 16'd6);
        check("fifth_after_pop", 34'(rsp_cnt > r0), 34'd1);
        wait_rsp(r0 + 6);
        @(negedge clk);
        check("full_acc",    34'(acc),        34'd20);
        check("full_sticky", 34'(err_sticky), 34'd3);
        check("full_starts", 34'(start_cyc.size() - s0), 34'd6);
        if (start_cyc.size() - s0 == 6) begin
            check("b2b_gap_12", 34'(start_cyc[s0 + 2] - start_cyc[s0 + 1]), 34'd3);
            check("b2b_gap_23", 34'(start_cyc[s0 + 3] - start_cyc[s0 + 2]), 34'd3);
        end
        check("exp_q_drained", 34'(exp_q.size()), 34'd0);
        check("final_idle",    34'(busy),          34'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waiting for alu_done.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  FIFO not full.
REQ-007 SHALL have port cmd_op  in  4  op code: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 nand, 8 nor, 9 xor, 10 xnor, 11 not, 12 preset, 13 clear, 14 nop, 15 reserved.
REQ-008 SHALL have port cmd_data  in  16  operand A.
REQ-009 SHALL have ports alu_start out 1, alu_op out 4, alu_a out 16, alu_b out 16: request to the shared ALU.
REQ-010 SHALL have ports alu_done in 1, alu_result in 32, alu_err in 2: ALU completion (err 01 overflow, 10 divide/mod by zero).
REQ-011 SHALL have ports rsp_valid out 1, rsp_result out 32, rsp_err out 2: per-command response.
REQ-012 SHALL have port acc out 32, the accumulator value.
REQ-013 SHALL have ports err_sticky out 2, busy out 1.

Function
REQ-014 SHALL accept a command on the clk edge where cmd_valid & cmd_ready, pushing {op,data} into the FIFO in order.
REQ-015 SHALL deassert cmd_ready when the FIFO holds FIFO_DEPTH entries; a pop and a push in the same cycle while full SHALL NOT be permitted (ready low).
REQ-016 SHALL run FSM IDLE -> ISSUE -> WAIT -> WB -> IDLE; IDLE leaves only when the FIFO is non-empty.
REQ-017 ISSUE SHALL pop one entry and drive alu_start high for exactly one cycle, with alu_a=data, alu_b=acc[15:0], alu_op=op.
REQ-018 Ops 12, 13, 14, 15 SHALL bypass the ALU (ISSUE -> WB, no alu_start): 12 result 32'hFFFF_FFFF, 13 result 0, 14 result acc, 15 result acc with err 2'b11.
REQ-019 WAIT SHALL hold alu_* outputs stable and move to WB on the first cycle alu_done=1, capturing alu_result and alu_err.
REQ-020 A timeout counter SHALL reset on entering WAIT; if TIMEOUT cycles elapse without alu_done, the FSM SHALL go to WB with result=acc and err 2'b11.
REQ-021 WB SHALL pulse rsp_valid for one cycle with rsp_result and rsp_err, and load acc with the result only when err==00.
REQ-022 On err!=00, acc SHALL keep its prior value; err_sticky SHALL OR in err and hold until reset.
REQ-023 err 01 SHALL be reported only for ops 0 and 1; for other ops alu_err[0] SHALL be masked.
REQ-024 alu_done arriving outside WAIT SHALL be ignored.
REQ-025 busy SHALL equal (state!=IDLE) | FIFO non-empty.
REQ-026 Back-to-back commands SHALL complete at one per 3 cycles minimum, given alu_done in the cycle after alu_start.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear FIFO, state to IDLE, acc=0, err_sticky=0, rsp_valid=0, alu_start=0, cmd_ready=0, with outputs data zero.
REQ-028 cmd_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-WAIT SHALL abandon the command with no response.

Structure
REQ-029 Op-code constants, err-code constants and state encoding SHALL live in a shared package alu_pkg.
REQ-030 The command FIFO SHALL be a sub-module cmd_fifo (parameter depth, width 20).

Verification
REQ-031 Reset, push add 11 (alu returns 11 next cycle) -> rsp_result 11, acc 11, rsp_err 00.
REQ-032 acc=11, push sub 15 -> alu_a 15, alu_b 11, acc 4; then div 8 with alu_err 10 -> rsp_err 10, acc stays 4, err_sticky 10.
REQ-033 Push 5 commands with alu_done stalled -> cmd_ready low after 4 accepted, 5th accepted after first pop; responses in order.
REQ-034 Push mul with alu_done never asserted -> rsp after 64 WAIT cycles, rsp_err 11, acc unchanged.
REQ-035 Push preset then clear -> acc 32'hFFFF_FFFF then 0, no alu_start pulses.
REQ-036 Assert rst_n low during WAIT -> no rsp_valid, acc 0, FIFO empty, stray alu_done ignored.
